// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file and its busy scoreboard.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);
    localparam int ZERO_REG  = 0;

    typedef logic signed [DEF_XLEN-1:0] xlen_t;
    typedef logic        [DEF_AW-1:0]   reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write flags: set on issue, cleared on writeback, with
// combinational release when the writeback lands in the same cycle as the read.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS  = DEF_NREGS,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    // NOTE: combinational blocks use blocking '=' so later statements see the
    // earlier updates; that ordering is what makes issue-set beat writeback-clear.
    always_comb begin
        // NOTE: assigning the full default first means every path drives
        // busy_next, so no latch can be inferred.
        busy_next = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) busy_next[wr_addr[j*AW +: AW]] = 1'b0;
        end
        if (iss_en) busy_next[iss_addr] = 1'b1;
        busy_next[ZERO_REG] = 1'b0;
    end

    // NOTE: clocked state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) busy <= '0;
        else       busy <= busy_next;
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [AW-1:0] a;
            logic          hit;
            a   = rd_addr[i*AW +: AW];
            hit = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == a)) hit = 1'b1;
            end
            rd_busy[i] = busy[a] & ~hit;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through bypass, hardwired x0,
// an unbypassed debug port and a pending-write scoreboard for hazard stalls.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = DEF_XLEN,
    parameter  int NREGS  = DEF_NREGS,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic [AW-1:0]          dbg_addr,
    output logic [XLEN-1:0]        dbg_data
);

    logic [XLEN-1:0]   mem [NREGS];
    logic [NUM_WR-1:0] wr_live;

    // Reset must hide in-flight writeback data on the bypass path as well.
    assign wr_live = wr_en & {NUM_WR{rstn}};

    // NOTE: the whole array is reset because software relies on every
    // register reading 0 after reset; this rules out a RAM macro here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            // Ascending order: the highest-index port's assignment lands last.
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != '0))
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] d;
            a = rd_addr[i*AW +: AW];
            d = mem[a];
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_live[j] && (wr_addr[j*AW +: AW] == a) && (a != '0))
                    d = wr_data[j*XLEN +: XLEN];
            end
            rd_data[i*XLEN +: XLEN] = d;
        end
    end

    // mem[0] is cleared by reset and never written, so no explicit x0 mux.
    assign dbg_data = mem[dbg_addr];

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk      (clk),
        .rstn     (rstn),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed literal checks plus randomized
// traffic compared every cycle against an array-based architectural model.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b1;
    logic [NUM_RD*AW-1:0]   rd_addr = '0;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en = '0;
    logic [NUM_WR*AW-1:0]   wr_addr = '0;
    logic [NUM_WR*XLEN-1:0] wr_data = '0;
    logic                   iss_en = 1'b0;
    logic [AW-1:0]          iss_addr = '0;
    logic [AW-1:0]          dbg_addr = '0;
    logic [XLEN-1:0]        dbg_data;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Architectural model: register contents and outstanding-write flags.
    logic [XLEN-1:0] m_mem  [NREGS];
    logic            m_busy [NREGS];

    regfile_mp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] wa(input int j);
        return wr_addr[j*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] wd(input int j);
        return wr_data[j*XLEN +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rdv(input int i);
        return rd_data[i*XLEN +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (!rstn || a == 0) return '0;
        v = m_mem[a];
        for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j] && wa(j) == a) v = wd(j);
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!rstn || a == 0) return 1'b0;
        for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j] && wa(j) == a) return 1'b0;
        return m_busy[a];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r]  <= '0;
                m_busy[r] <= 1'b0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wa(j) != 0) m_mem[wa(j)] <= wd(j);
                if (wr_en[j]) m_busy[wa(j)] <= 1'b0;
            end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NUM_RD; i++) begin
                check($sformatf("model rd_data%0d", i), rdv(i), exp_rd(rd_addr[i*AW +: AW]));
                check($sformatf("model rd_busy%0d", i), 32'(rd_busy[i]),
                      32'(exp_busy(rd_addr[i*AW +: AW])));
            end
            check("model dbg_data", dbg_data,
                  (!rstn || dbg_addr == 0) ? '0 : m_mem[dbg_addr]);
        end
    end

    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[j]                 = 1'b1;
        wr_addr[j*AW +: AW]      = a;
        wr_data[j*XLEN +: XLEN]  = d;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr[0 +: AW]  = a0;
        rd_addr[AW +: AW] = a1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset asserted mid-cycle, before any clock edge.
        #3 rstn = 1'b0;
        chk_on = 1'b1;
        set_rd(5, 6);
        #1;
        check("reset rd0", rdv(0), 32'd0);
        check("reset rd1", rdv(1), 32'd0);
        check("reset busy", 32'(rd_busy), 32'd0);
        @(posedge clk);
        #2 rstn = 1'b1;
        #1;
        check("post-reset rd0", rdv(0), 32'd0);
        check("post-reset busy", 32'(rd_busy), 32'd0);
        tick();

        // Write and read back, including a negative value.
        set_wr(0, 10, 32'd12983);
        tick();
        idle();
        set_wr(0, 30, 32'hFFFF_FEBC); // -324
        tick();
        idle();
        set_rd(10, 30);
        dbg_addr = 10;
        #1;
        check("readback x10", rdv(0), 32'd12983);
        check("readback x30", rdv(1), 32'hFFFF_FEBC);
        check("dbg x10", dbg_data, 32'd12983);
        tick();

        // x0 is hardwired: writes dropped, never busy.
        set_wr(0, 0, 32'd500);
        iss_en = 1'b1;
        iss_addr = 0;
        set_rd(0, 0);
        #1;
        check("x0 same-cycle", rdv(0), 32'd0);
        tick();
        idle();
        dbg_addr = 0;
        #1;
        check("x0 next-cycle", rdv(0), 32'd0);
        check("x0 busy", 32'(rd_busy[0]), 32'd0);
        check("x0 dbg", dbg_data, 32'd0);
        tick();

        // Bypass and write-port priority.
        set_wr(0, 7, 32'd11);
        tick();
        idle();
        set_wr(0, 7, 32'd99);
        set_rd(7, 0);
        dbg_addr = 7;
        #1;
        check("bypass rd", rdv(0), 32'd99);
        check("bypass dbg before", dbg_data, 32'd11);
        tick();
        idle();
        #1;
        check("bypass dbg after", dbg_data, 32'd99);
        set_wr(0, 7, 32'd1);
        set_wr(1, 7, 32'd2);
        #1;
        check("dual-write bypass", rdv(0), 32'd2);
        tick();
        idle();
        #1;
        check("dual-write stored", dbg_data, 32'd2);
        tick();

        // Scoreboard: issue, release by writeback, set-wins.
        iss_en = 1'b1;
        iss_addr = 12;
        set_rd(12, 12);
        #1;
        check("busy before edge", 32'(rd_busy[0]), 32'd0);
        tick();
        idle();
        #1;
        check("busy after issue", 32'(rd_busy[0]), 32'd1);
        set_wr(0, 12, 32'd42);
        #1;
        check("busy released comb", 32'(rd_busy[0]), 32'd0);
        tick();
        idle();
        #1;
        check("busy cleared", 32'(rd_busy[1]), 32'd0);
        set_wr(1, 12, 32'd43);
        iss_en = 1'b1;
        iss_addr = 12;
        tick();
        idle();
        #1;
        check("set wins", 32'(rd_busy[0]), 32'd1);
        check("set wins data", rdv(1), 32'd43);
        tick();

        // Reset mid-operation with a write in flight.
        set_wr(0, 3, 32'd77);
        iss_en = 1'b1;
        iss_addr = 3;
        tick();
        idle();
        set_rd(3, 3);
        dbg_addr = 3;
        #1;
        check("x3 stored", rdv(0), 32'd77);
        check("x3 busy", 32'(rd_busy[0]), 32'd1);
        set_wr(0, 3, 32'd5);
        #1 rstn = 1'b0;
        #1;
        check("reset rd x3", rdv(0), 32'd0);
        check("reset busy x3", 32'(rd_busy[1]), 32'd0);
        check("reset dbg x3", dbg_data, 32'd0);
        tick();
        idle();
        rstn = 1'b1;
        tick();
        check("x3 after reset", rdv(0), 32'd0);

        // Randomized traffic; a narrow address window forces collisions.
        for (int n = 0; n < 3000; n++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                wr_en[j] = 1'($urandom_range(0, 1));
                wr_addr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ?
                    AW'($urandom_range(0, NREGS-1)) : AW'($urandom_range(0, 7));
                wr_data[j*XLEN +: XLEN] = $urandom;
            end
            for (int i = 0; i < NUM_RD; i++)
                rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = AW'($urandom_range(0, 7));
            dbg_addr = AW'($urandom_range(0, 7));
            rstn     = ($urandom_range(0, 199) != 0);
            tick();
        end
        rstn = 1'b1;
        idle();
        tick();
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file with write-through bypass and a per-register pending-write scoreboard.
- Sits in the decode stage of the pipelined RISC-V core and replaces the fixed 2-read/1-write file.
- Read ports see same-cycle writeback data.
- Busy flags let hazard logic stall on registers with an outstanding long-latency write.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, 2..64).
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- AW, $clog2(NREGS), register address width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data, signed two's complement; port i in [i*XLEN +: XLEN].
- rd_busy  out  NUM_RD  1 = addressed register has a pending write.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*XLEN  write data.
- iss_en  in  1  issue strobe: mark iss_addr as pending.
- iss_addr  in  AW  destination register of the issuing instruction.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data (no bypass).

Behaviour:
- Reset (rstn=0, asynchronous, no clock needed):
  - all NREGS registers cleared to 0; all busy bits cleared.
  - Consequently rd_data=0, rd_busy=0, dbg_data=0 for every address while reset is held and on the first cycle after.
- Register 0 is hardwired:
  - writes to address 0 are discarded;
  - reads of address 0 return 0 with rd_busy=0, including the bypass path;
  - iss_addr=0 never sets busy.
- Writes:
  - On a rising clk with wr_en[j]=1 and wr_addr[j]!=0, mem[wr_addr[j]] <= wr_data[j]. Latency 1 cycle to storage.
  - If two write ports target the same register in one cycle, the higher port index wins, both in storage and in bypass.
- Reads:
  - Combinational, zero latency, no clock required.
  - rd_data[i] = wr_data[j] when wr_en[j]=1, wr_addr[j]==rd_addr[i] and rd_addr[i]!=0 (highest matching j wins); otherwise mem[rd_addr[i]].
  - dbg_data reads storage only (never bypassed), returns 0 for address 0.
- Scoreboard:
  - On a rising clk, busy[iss_addr] <= 1 if iss_en=1; busy[wr_addr[j]] <= 0 for each wr_en[j]=1.
  - Same register issued and written in the same cycle: set wins (the new instruction's write is still outstanding).
  - rd_busy[i] = busy[rd_addr[i]] & ~(any wr_en[j] with wr_addr[j]==rd_addr[i]). A same-cycle writeback releases the stall combinationally, consistent with the bypassed data.
  - Writing a register that is not busy is legal; busy stays 0.
- Reset asserted mid-operation: state clears immediately regardless of wr_en/iss_en; no write in flight survives.
- No X propagation: out-of-range addresses are impossible by construction (NREGS = 2^AW).

Decomposition:
- Package regfile_pkg: default XLEN, NREGS, ZERO_REG=0 constant, typedef xlen_t (logic signed [XLEN-1:0]), typedef reg_addr_t.
- Sub-module regfile_scoreboard: holds the busy vector, issue/clear update, set-wins priority, x0 masking and the rd_busy combinational outputs.
- Storage, write priority and bypass muxes stay in regfile_mp.

Test Plan:
- Reset then read: assert rstn=0 mid-cycle, release; rd_addr=5,6 -> rd_data=0,0, rd_busy=0,0.
- Write/read back: write 12983 to x10, then -324 to x30 on separate edges; next cycle rd_addr=10,30 -> 12983, -324; dbg_addr=10 -> 12983.
- x0 protection: wr_en=1, wr_addr=0, wr_data=500; rd_addr=0 in the same and the next cycle -> 0; iss_en=1, iss_addr=0 -> rd_busy for x0 stays 0.
- Bypass: x7 holds 11; in one cycle wr_en=1, x7<-99 with rd_addr=7 -> rd_data=99 before the edge, dbg_data=11 before / 99 after. With NUM_WR=2, both ports write x7 (1 and 2) -> rd_data=2 and stored value 2.
- Scoreboard:
  - iss_en with x12 -> rd_busy=1 from the next cycle;
  - writeback to x12 -> rd_busy=0 combinationally in that cycle;
  - simultaneous iss x12 and write x12 -> busy remains 1 after the edge.
- Reset mid-operation: x3=77 with busy[x3]=1, assert rstn with wr_en=1 on x3 -> x3 reads 0, busy 0 immediately, before any clock edge.
